// File: rtl/vga_bounce_box.sv
// Pixel generator behind the 640x480 VGA sync generator: draws a bouncing square
// that moves once per frame, changes colour on every bounce, and delays syncs to match.
module vga_bounce_box #(
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480,
    parameter int BOX_SIZE  = 32,
    parameter int STEP      = 1,
    parameter int START_X   = 0,
    parameter int START_Y   = 0,
    parameter int COLOR_W   = 4
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    input  logic [9:0]         h_count,
    input  logic [9:0]         v_count,
    input  logic               display_en,
    input  logic               pause,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               h_sync_out,
    output logic               v_sync_out,
    output logic [7:0]         bounce_cnt
);

    localparam logic [10:0] L_MAXX    = 11'(H_DISPLAY - BOX_SIZE);
    localparam logic [10:0] L_MAXY    = 11'(V_DISPLAY - BOX_SIZE);
    localparam logic [10:0] L_BOX     = 11'(BOX_SIZE);
    localparam logic [10:0] L_STEP    = 11'(STEP);
    localparam logic [10:0] L_START_X = 11'(START_X);
    localparam logic [10:0] L_START_Y = 11'(START_Y);
    localparam logic [9:0]  L_VTICK   = 10'(V_DISPLAY);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    // One axis of motion: returns {hit, dir_neg, pos}; the box is clamped at the wall it reaches.
    function automatic logic [12:0] axis_step(input logic [10:0] pos, input logic dir_neg,
                                              input logic [10:0] lim);
        logic [12:0] res;
        if (!dir_neg) begin
            if (pos + L_STEP >= lim) res = {1'b1, 1'b1, lim};
            else                     res = {1'b0, 1'b0, pos + L_STEP};
        end else begin
            if (pos <= L_STEP) res = {1'b1, 1'b0, 11'd0};
            else               res = {1'b0, 1'b1, pos - L_STEP};
        end
        return res;
    endfunction

    function automatic logic [11:0] palette(input logic [2:0] idx);
        logic [11:0] rgb;
        case (idx)
            3'd0:    rgb = 12'hFFF;
            3'd1:    rgb = 12'hF00;
            3'd2:    rgb = 12'h0F0;
            3'd3:    rgb = 12'h00F;
            3'd4:    rgb = 12'hFF0;
            3'd5:    rgb = 12'h0FF;
            3'd6:    rgb = 12'hF0F;
            3'd7:    rgb = 12'hF80;
            default: rgb = 12'hFFF;
        endcase
        return rgb;
    endfunction

    // Palette nibbles are MSB-aligned into the channel width.
    function automatic logic [COLOR_W-1:0] chan(input logic [3:0] nib);
        return COLOR_W'({nib, {COLOR_W{1'b0}}} >> 4);
    endfunction

    state_t            r_state, w_state_nxt;
    logic              w_move, w_frame_tick, w_inside;
    logic [9:0]        r_vprev;
    logic [10:0]       r_pos_x, r_pos_y;
    logic              r_dir_x, r_dir_y;
    logic [2:0]        r_col;
    logic [7:0]        r_bounce;
    logic              r_de1, r_inside, r_hs1, r_vs1, r_hs2, r_vs2;
    logic [COLOR_W-1:0] r_red, r_grn, r_blu;
    logic [12:0]       w_nx, w_ny;
    logic [11:0]       w_pal;

    // The first blanking line starts a frame tick, so motion never happens mid-picture.
    assign w_frame_tick = (v_count == L_VTICK) && (r_vprev != L_VTICK);
    assign w_nx  = axis_step(r_pos_x, r_dir_x, L_MAXX);
    assign w_ny  = axis_step(r_pos_y, r_dir_y, L_MAXY);
    assign w_pal = palette(r_col);
    assign w_inside = display_en
                   && ({1'b0, h_count} >= r_pos_x) && ({1'b0, h_count} < r_pos_x + L_BOX)
                   && ({1'b0, v_count} >= r_pos_y) && ({1'b0, v_count} < r_pos_y + L_BOX);

    // Run/pause state register
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // Run/pause next state; leaving PAUSED does not move on that same tick
    always_comb begin
        w_state_nxt = r_state;
        w_move      = 1'b0;
        if (w_frame_tick) begin
            case (r_state)
                ST_RUN: begin
                    if (pause) w_state_nxt = ST_PAUSED;
                    else       w_move      = 1'b1;
                end
                ST_PAUSED: begin
                    if (!pause) w_state_nxt = ST_RUN;
                    else        w_state_nxt = ST_PAUSED;
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Box position, direction, colour and bounce count; a corner hit counts once
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_vprev  <= 10'd0;
            r_pos_x  <= L_START_X;
            r_pos_y  <= L_START_Y;
            r_dir_x  <= 1'b0;
            r_dir_y  <= 1'b0;
            r_col    <= 3'd0;
            r_bounce <= 8'd0;
        end else begin
            r_vprev <= v_count;
            if (w_move) begin
                r_pos_x <= w_nx[10:0];
                r_dir_x <= w_nx[11];
                r_pos_y <= w_ny[10:0];
                r_dir_y <= w_ny[11];
                if (w_nx[12] || w_ny[12]) begin
                    r_col    <= r_col + 3'd1;
                    r_bounce <= r_bounce + 8'd1;
                end
            end
        end
    end

    // Two-stage pixel pipeline with syncs carried alongside
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_de1    <= 1'b0;
            r_inside <= 1'b0;
            r_hs1    <= 1'b1;
            r_vs1    <= 1'b1;
            r_hs2    <= 1'b1;
            r_vs2    <= 1'b1;
            r_red    <= '0;
            r_grn    <= '0;
            r_blu    <= '0;
        end else begin
            r_de1    <= display_en;
            r_inside <= w_inside;
            r_hs1    <= h_sync_in;
            r_vs1    <= v_sync_in;
            r_hs2    <= r_hs1;
            r_vs2    <= r_vs1;
            if (!r_de1) begin
                r_red <= '0;
                r_grn <= '0;
                r_blu <= '0;
            end else if (r_inside) begin
                r_red <= chan(w_pal[11:8]);
                r_grn <= chan(w_pal[7:4]);
                r_blu <= chan(w_pal[3:0]);
            end else begin
                r_red <= chan(4'h0);
                r_grn <= chan(4'h0);
                r_blu <= chan(4'h4);
            end
        end
    end

    assign r          = r_red;
    assign g          = r_grn;
    assign b          = r_blu;
    assign h_sync_out = r_hs2;
    assign v_sync_out = r_vs2;
    assign bounce_cnt = r_bounce;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed bench for vga_bounce_box: three instances (start positions 0/0, 600/0, 607/447)
// share the pixel stimulus; frames are compressed to a v_count 479 -> 480 transition.
module tb_vga_bounce_box;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       hs_in, vs_in, de, pause_a, pause_bc;
    logic [9:0] h_count, v_count;
    logic [3:0] o_r [3];
    logic [3:0] o_g [3];
    logic [3:0] o_b [3];
    logic       o_hs [3];
    logic       o_vs [3];
    logic [7:0] o_bc [3];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk_in = ~clk_in;

    vga_bounce_box u_a (
        .clk_in(clk_in), .reset(reset), .h_sync_in(hs_in), .v_sync_in(vs_in),
        .h_count(h_count), .v_count(v_count), .display_en(de), .pause(pause_a),
        .r(o_r[0]), .g(o_g[0]), .b(o_b[0]), .h_sync_out(o_hs[0]), .v_sync_out(o_vs[0]),
        .bounce_cnt(o_bc[0])
    );

    vga_bounce_box #(.START_X(600)) u_b (
        .clk_in(clk_in), .reset(reset), .h_sync_in(hs_in), .v_sync_in(vs_in),
        .h_count(h_count), .v_count(v_count), .display_en(de), .pause(pause_bc),
        .r(o_r[1]), .g(o_g[1]), .b(o_b[1]), .h_sync_out(o_hs[1]), .v_sync_out(o_vs[1]),
        .bounce_cnt(o_bc[1])
    );

    vga_bounce_box #(.START_X(607), .START_Y(447)) u_c (
        .clk_in(clk_in), .reset(reset), .h_sync_in(hs_in), .v_sync_in(vs_in),
        .h_count(h_count), .v_count(v_count), .display_en(de), .pause(pause_bc),
        .r(o_r[2]), .g(o_g[2]), .b(o_b[2]), .h_sync_out(o_hs[2]), .v_sync_out(o_vs[2]),
        .bounce_cnt(o_bc[2])
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_val(input logic [11:0] obs, input logic [11:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rgb(input int d, input logic [11:0] exp, input string tag);
        chk_val({o_r[d], o_g[d], o_b[d]}, exp, tag);
    endtask

    task automatic probe(input int d, input int h, input int v, input logic en,
                         input logic [11:0] exp, input string tag);
        h_count = 10'(h);
        v_count = 10'(v);
        de      = en;
        step();
        step();
        chk_rgb(d, exp, tag);
    endtask

    // Pins the box top-left corner: (x,y) in the box, the pixel left of it and above it outside.
    task automatic box(input int d, input int x, input int y, input logic [11:0] col,
                       input string tag);
        probe(d, x, y, 1'b1, col, {tag, "_in"});
        if (x > 0) probe(d, x - 1, y, 1'b1, 12'h004, {tag, "_left"});
        if (y > 0) probe(d, x, y - 1, 1'b1, 12'h004, {tag, "_above"});
    endtask

    task automatic frame();
        de      = 1'b0;
        v_count = 10'd479;
        step();
        v_count = 10'd480;
        step();
        v_count = 10'd0;
    endtask

    initial begin
        logic [7:0] hp;
        logic [7:0] vp;
        hp = 8'b1011_0010;
        vp = 8'b0110_1101;
        reset = 1'b0; hs_in = 1'b0; vs_in = 1'b0; de = 1'b1;
        pause_a = 1'b0; pause_bc = 1'b0; h_count = 10'd0; v_count = 10'd0;
        repeat (3) step();
        chk_rgb(0, 12'h000, "rst_rgb");
        chk_val({11'd0, o_hs[0]}, 12'd1, "rst_hs");
        chk_val({11'd0, o_vs[0]}, 12'd1, "rst_vs");
        chk_val({4'd0, o_bc[0]}, 12'd0, "rst_bc");

        reset = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
        step();
        chk_rgb(0, 12'h000, "lat_cycle1");
        step();
        chk_rgb(0, 12'hFFF, "lat_cycle2");
        probe(0, 32, 0, 1'b1, 12'h004, "px_32_0");
        probe(0, 31, 0, 1'b1, 12'hFFF, "px_31_0");
        probe(0, 0, 32, 1'b1, 12'h004, "px_0_32");
        probe(0, 0, 31, 1'b1, 12'hFFF, "px_0_31");
        probe(0, 0, 0, 1'b0, 12'h000, "px_blank");

        for (int i = 0; i < 8; i++) begin
            hs_in = hp[i];
            vs_in = vp[i];
            step();
            if (i >= 1) begin
                chk_val({11'd0, o_hs[0]}, {11'd0, hp[i-1]}, "hs_delay");
                chk_val({11'd0, o_vs[0]}, {11'd0, vp[i-1]}, "vs_delay");
            end
        end
        hs_in = 1'b1; vs_in = 1'b1;

        frame();
        chk_val({4'd0, o_bc[2]}, 12'd1, "corner_bc");
        box(2, 608, 448, 12'hF00, "corner_pos");
        frame();
        chk_val({4'd0, o_bc[2]}, 12'd1, "corner_bc2");
        box(2, 607, 447, 12'hF00, "corner_back");

        repeat (5) frame();
        chk_val({4'd0, o_bc[1]}, 12'd0, "b_f7_bc");
        box(1, 607, 7, 12'hFFF, "b_f7");
        frame();
        chk_val({4'd0, o_bc[1]}, 12'd1, "b_f8_bc");
        box(1, 608, 8, 12'hF00, "b_f8");
        probe(1, 639, 8, 1'b1, 12'hF00, "b_f8_right");
        frame();
        box(1, 607, 9, 12'hF00, "b_f9");
        probe(1, 639, 9, 1'b1, 12'h004, "b_f9_right");
        chk_val({4'd0, o_bc[0]}, 12'd0, "a_f9_bc");
        box(0, 9, 9, 12'hFFF, "a_f9");

        repeat (2) frame();
        box(0, 11, 11, 12'hFFF, "a_prepause");
        pause_a = 1'b1;
        repeat (2) frame();
        box(0, 11, 11, 12'hFFF, "a_paused_mid");
        repeat (2) frame();
        box(0, 11, 11, 12'hFFF, "a_paused_end");
        pause_a = 1'b0;
        frame();
        box(0, 11, 11, 12'hFFF, "a_unpause_tick");
        frame();
        box(0, 12, 12, 12'hFFF, "a_resumed");

        v_count = 10'd100;
        pause_a = 1'b1;
        repeat (3) step();
        pause_a = 1'b0;
        step();
        box(0, 12, 12, 12'hFFF, "a_toggle");
        frame();
        box(0, 13, 13, 12'hFFF, "a_after_toggle");

        chk_val({4'd0, o_bc[1]}, 12'd1, "b_pre_rst_bc");
        box(1, 598, 18, 12'hF00, "b_pre_rst");
        h_count = 10'd100; v_count = 10'd200; de = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
        repeat (3) step();
        chk_val({11'd0, o_hs[0]}, 12'd0, "pre_rst_hs");
        #2;
        reset = 1'b0;
        #1;
        chk_rgb(0, 12'h000, "midrst_rgb");
        chk_val({11'd0, o_hs[0]}, 12'd1, "midrst_hs");
        chk_val({11'd0, o_vs[0]}, 12'd1, "midrst_vs");
        chk_val({4'd0, o_bc[1]}, 12'd0, "midrst_bc_b");
        chk_val({4'd0, o_bc[2]}, 12'd0, "midrst_bc_c");
        step();
        reset = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
        box(1, 600, 0, 12'hFFF, "b_rst_pos");
        box(2, 607, 447, 12'hFFF, "c_rst_pos");
        frame();
        box(1, 601, 1, 12'hFFF, "b_first_move");
        box(0, 1, 1, 12'hFFF, "a_first_move");
        chk_val({4'd0, o_bc[2]}, 12'd1, "c_rehit_bc");
        box(2, 608, 448, 12'hF00, "c_rehit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
